// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the two-source character-LCD write arbiter.
package lcd_arb_pkg;
  localparam int LCD_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic SRC_KB  = 1'b0;
  localparam logic SRC_CPU = 1'b1;
endpackage

// File: rtl/lcd_req_fifo.sv
// Small per-source request FIFO; a push while full is accepted only when the
// same cycle also pops, so the occupancy stays at DEPTH.
module lcd_req_fifo
  import lcd_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [LCD_DW-1:0] din,
  output logic [LCD_DW-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [LCD_DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic              w_pop, w_push;

  assign w_pop  = pop & (r_count != '0);
  assign w_push = push & ((r_count != FULL_CNT) | w_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  assign head  = r_mem[r_rptr];
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter between keyboard and CPU byte streams onto one LCD
// write port, with a fixed idle gap after every issued write.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2000,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              kb_valid,
  input  logic [LCD_DW-1:0] kb_data,
  input  logic              cpu_valid,
  input  logic [LCD_DW-1:0] cpu_data,
  input  logic              clear_ovf,
  output logic              lcd_write_en,
  output logic [LCD_DW-1:0] lcd_data,
  output logic              grant_src,
  output logic              kb_overflow,
  output logic              cpu_overflow,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]             w_valid, w_pop, w_full, w_empty, w_ne, w_drop;
  logic [1:0][LCD_DW-1:0] w_din, w_head;
  logic [1:0][AW:0]       w_cnt;
  logic                   w_sel, w_start;

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we, r_src, r_last_grant, r_busy;
  logic [LCD_DW-1:0] r_data;
  logic [1:0]        r_ovf;

  // Index 0 is the keyboard (SRC_KB), index 1 the CPU (SRC_CPU).
  assign w_valid = {cpu_valid, kb_valid};
  assign w_din   = {cpu_data, kb_data};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    lcd_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (w_valid[gi]),
      .pop    (w_pop[gi]),
      .din    (w_din[gi]),
      .head   (w_head[gi]),
      .full   (w_full[gi]),
      .empty  (w_empty[gi]),
      .count  (w_cnt[gi])
    );
    assign w_ne[gi]   = (w_cnt[gi] != '0);
    assign w_drop[gi] = w_valid[gi] & w_full[gi] & ~w_pop[gi];
    assign w_pop[gi]  = w_start & (w_sel == 1'(gi)) & ~w_empty[gi];
  end

  // On a tie the source that did not win last time gets the slot.
  assign w_sel   = (w_ne[0] & w_ne[1]) ? ~r_last_grant : w_ne[1];
  assign w_start = (r_state == ST_IDLE) & (|w_ne);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_data       <= '0;
      r_src        <= SRC_KB;
      r_last_grant <= SRC_CPU;
      r_busy       <= 1'b0;
      r_ovf        <= '0;
    end else begin
      r_we <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (w_drop[i])     r_ovf[i] <= 1'b1;
        else if (clear_ovf) r_ovf[i] <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_data       <= w_head[w_sel];
            r_src        <= w_sel;
            r_last_grant <= w_sel;
            r_we         <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CNT_W'(GAP_CYCLES - 1);
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lcd_write_en = r_we;
  assign lcd_data     = r_data;
  assign grant_src    = r_src;
  assign kb_overflow  = r_ovf[0];
  assign cpu_overflow = r_ovf[1];
  assign busy         = r_busy;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: a queue/timestamp model checked every
// cycle, plus literal expectations for each scenario.
module tb_lcd_write_arbiter;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0, resetn = 1'b0;
  logic       kb_valid = 1'b0, cpu_valid = 1'b0, clear_ovf = 1'b0;
  logic [7:0] kb_data = '0, cpu_data = '0;
  logic       lcd_write_en, grant_src, kb_overflow, cpu_overflow, busy;
  logic [7:0] lcd_data;

  lcd_write_arbiter #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .kb_valid     (kb_valid),
    .kb_data      (kb_data),
    .cpu_valid    (cpu_valid),
    .cpu_data     (cpu_data),
    .clear_ovf    (clear_ovf),
    .lcd_write_en (lcd_write_en),
    .lcd_data     (lcd_data),
    .grant_src    (grant_src),
    .kb_overflow  (kb_overflow),
    .cpu_overflow (cpu_overflow),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  int tcyc = 0;
  always @(posedge clock) tcyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: per-source queues; the arbiter may pick once m_cyc reaches m_free,
  // the pick shows as a strobe next cycle, then busy spans GAP+1 cycles.
  logic [7:0] kq[$], cq[$];
  int         m_cyc, m_free, m_issue, m_busy_to;
  logic [7:0] m_data;
  logic       m_src, m_lg, m_kovf, m_covf;

  task automatic m_reset();
    kq.delete(); cq.delete();
    m_cyc = 0; m_free = 0; m_issue = -100; m_busy_to = -100;
    m_data = '0; m_src = 1'b0; m_lg = 1'b1; m_kovf = 1'b0; m_covf = 1'b0;
  endtask

  initial m_reset();

  always @(posedge clock or negedge resetn) begin
    logic s;
    if (!resetn) m_reset();
    else begin
      if (m_cyc >= m_free && (kq.size() > 0 || cq.size() > 0)) begin
        if (kq.size() > 0 && cq.size() > 0) s = ~m_lg;
        else s = (cq.size() > 0);
        m_data    = s ? cq.pop_front() : kq.pop_front();
        m_src     = s;
        m_lg      = s;
        m_issue   = m_cyc + 1;
        m_busy_to = m_cyc + GAP + 1;
        m_free    = m_cyc + GAP + 2;
      end
      if (kb_valid && kq.size() >= DEPTH) m_kovf = 1'b1;
      else begin
        if (kb_valid) kq.push_back(kb_data);
        if (clear_ovf) m_kovf = 1'b0;
      end
      if (cpu_valid && cq.size() >= DEPTH) m_covf = 1'b1;
      else begin
        if (cpu_valid) cq.push_back(cpu_data);
        if (clear_ovf) m_covf = 1'b0;
      end
      m_cyc++;
    end
  end

  logic [7:0] lg_data[$];
  int         lg_cyc[$];
  logic       lg_src[$];

  always @(negedge clock) begin
    if (resetn) begin
      chk("write_en", lcd_write_en, m_cyc == m_issue);
      chk("lcd_data", lcd_data, m_data);
      chk("grant_src", grant_src, m_src);
      chk("busy", busy, (m_cyc >= m_issue) && (m_cyc <= m_busy_to));
      chk("kb_overflow", kb_overflow, m_kovf);
      chk("cpu_overflow", cpu_overflow, m_covf);
      if (lcd_write_en) begin
        lg_data.push_back(lcd_data);
        lg_cyc.push_back(tcyc);
        lg_src.push_back(grant_src);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (kq.size() == 0 && cq.size() == 0 && m_cyc >= m_free) return;
      step();
    end
    n_cmp++; n_err++;
    $display("FAIL wait_idle: still busy after 300 cycles");
  endtask

  task automatic wait_writes(int n);
    for (int i = 0; i < 100; i++) begin
      if (lg_data.size() >= n) return;
      step();
    end
    n_cmp++; n_err++;
    $display("FAIL wait_writes: got %0d writes expected %0d", lg_data.size(), n);
  endtask

  initial begin
    int idx, t0;
    logic [7:0] fair_exp [6];
    fair_exp = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};

    step(2);
    chk("rst_we", lcd_write_en, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src", grant_src, 0);
    resetn = 1'b1;
    step(3);

    // Single key: strobe two cycles after the push
    idx = lg_data.size();
    kb_valid = 1'b1; kb_data = 8'h1C; t0 = tcyc;
    step(); kb_valid = 1'b0;
    wait_idle(); step();
    chk("single_count", lg_data.size(), idx + 1);
    chk("single_latency", lg_cyc[idx] - t0, 2);
    chk("single_data", lg_data[idx], 8'h1C);
    chk("single_src", lg_src[idx], 0);

    // Tie right after reset: keyboard first, then cpu, GAP+2 apart
    resetn = 1'b0; step(); resetn = 1'b1; step();
    idx = lg_data.size();
    kb_valid = 1'b1; kb_data = 8'h41; cpu_valid = 1'b1; cpu_data = 8'h42;
    step(); kb_valid = 1'b0; cpu_valid = 1'b0;
    wait_idle(); step();
    chk("tie_count", lg_data.size(), idx + 2);
    chk("tie_first", lg_data[idx], 8'h41);
    chk("tie_second", lg_data[idx+1], 8'h42);
    chk("tie_src", lg_src[idx+1], 1);
    chk("tie_spacing", lg_cyc[idx+1] - lg_cyc[idx], GAP + 2);

    // Fairness: alternating grants
    idx = lg_data.size();
    for (int i = 0; i < 3; i++) begin
      kb_valid = 1'b1; kb_data = fair_exp[2*i];
      cpu_valid = 1'b1; cpu_data = fair_exp[2*i+1];
      step();
    end
    kb_valid = 1'b0; cpu_valid = 1'b0;
    wait_idle(); step();
    chk("fair_count", lg_data.size(), idx + 6);
    for (int i = 0; i < 6; i++) chk("fair_order", lg_data[idx+i], fair_exp[i]);

    // Overflow: six back-to-back cpu pushes, sixth dropped
    idx = lg_data.size();
    for (int i = 0; i < 6; i++) begin
      cpu_valid = 1'b1; cpu_data = 8'(i); step();
    end
    cpu_valid = 1'b0;
    chk("ovf_set", cpu_overflow, 1);
    chk("ovf_kb_clear", kb_overflow, 0);
    wait_idle(); step();
    chk("ovf_count", lg_data.size(), idx + 5);
    for (int i = 0; i < 5; i++) chk("ovf_order", lg_data[idx+i], i);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    chk("ovf_cleared", cpu_overflow, 0);

    // Drop in the same cycle as clear_ovf: flag stays set
    for (int i = 0; i < 6; i++) begin
      cpu_valid = 1'b1; cpu_data = 8'(8'h10 + i);
      clear_ovf = (i == 5); step();
    end
    cpu_valid = 1'b0; clear_ovf = 1'b0;
    chk("ovf_set_wins", cpu_overflow, 1);
    wait_idle(); step();

    // Async reset mid-gap with two bytes queued
    idx = lg_data.size();
    for (int i = 0; i < 3; i++) begin
      kb_valid = 1'b1; kb_data = 8'(8'h61 + i); step();
    end
    kb_valid = 1'b0;
    wait_writes(idx + 1);
    step(2);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_data", lcd_data, 8'h61);
    #3 resetn = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_data", lcd_data, 0);
    chk("arst_we", lcd_write_en, 0);
    chk("arst_ovf", cpu_overflow, 0);
    step(2); resetn = 1'b1;
    step(20);
    chk("arst_no_writes", lg_data.size(), idx + 1);
    kb_valid = 1'b1; kb_data = 8'h77; step(); kb_valid = 1'b0;
    wait_idle(); step();
    chk("post_rst_write", lg_data[lg_data.size()-1], 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
Shares the single character-LCD write port between two requesters: the PS/2 keyboard path (key-pressed strobe plus scancode byte) and the processor (LCD write enable plus data word). Each source feeds its own small FIFO. A round-robin scheduler drains the FIFOs and emits one-cycle write strobes, spaced by a minimum gap so the LCD controller can finish each character. The block sits in the top level between the processor/PS2_Interface outputs and the lcd controller's write-enable/data inputs.

Parameters:
FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.
GAP_CYCLES, 2000, idle cycles enforced after each issued write; at least 1.
CNT_W, 16, gap counter width; must hold GAP_CYCLES-1.

Ports:
clock  in  1  system clock; all logic on the rising edge.
resetn  in  1  asynchronous active-low reset.
kb_valid  in  1  one-cycle strobe from the keyboard (ps2_key_pressed).
kb_data  in  8  keyboard byte (ps2_out); sampled when kb_valid=1.
cpu_valid  in  1  processor LCD write enable; one push per high cycle.
cpu_data  in  8  processor LCD byte (lcd_write_data[7:0]).
clear_ovf  in  1  synchronous clear of both overflow flags.
lcd_write_en  out  1  one-cycle write strobe to the LCD controller.
lcd_data  out  8  byte for the LCD; held stable from ISSUE until the next ISSUE.
grant_src  out  1  source of the last issued write: 0 = keyboard, 1 = cpu.
kb_overflow  out  1  sticky; set when a keyboard push was dropped.
cpu_overflow  out  1  sticky; set when a cpu push was dropped.
busy  out  1  high in the ISSUE and GAP states.

Behaviour:
- Reset (resetn=0, takes effect immediately without a clock edge):
  - FIFOs empty; state IDLE; gap counter 0.
  - lcd_write_en=0, lcd_data=0, grant_src=0, both overflow flags 0, busy=0.
  - last_grant=1, so the first tie goes to the keyboard.
- FIFO push:
  - On valid=1, push if not full. If full, drop the byte and set that source's overflow flag.
  - Exception: if that FIFO is popped in the same cycle, a push to a full FIFO is accepted and the count is unchanged.
  - Push to an empty FIFO: the byte is visible as not-empty on the next cycle. There is no bypass.
- Overflow flags: clear_ovf clears both. If a drop and clear_ovf occur in the same cycle, set wins.
- State machine states: IDLE, ISSUE, GAP.
- IDLE:
  - If neither FIFO is non-empty, stay in IDLE.
  - If exactly one FIFO is non-empty, select it.
  - If both are non-empty, select the source that is not last_grant.
  - Pop the selected FIFO, latch its head into the data register, record the source, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - lcd_write_en=1; lcd_data = latched byte.
  - grant_src and last_grant update to the selected source.
  - Load the gap counter with GAP_CYCLES-1; go to GAP.
- GAP: decrement the counter each cycle. When the counter is 0, go to IDLE.
- Timing:
  - Latency from a valid strobe at cycle t, with the block in IDLE and both FIFOs empty: lcd_write_en high at cycle t+2.
  - Minimum spacing between consecutive lcd_write_en pulses: GAP_CYCLES+2 cycles.
- No back-pressure toward sources. Ordering within a source is preserved. Bytes are never duplicated.
- Reset asserted mid-GAP or mid-ISSUE: all state is discarded, including FIFO contents.

Decomposition:
- Shared package lcd_arb_pkg:
  - State encoding constants ST_IDLE, ST_ISSUE, ST_GAP.
  - Source IDs SRC_KB=0, SRC_CPU=1.
  - Data width constant LCD_DW=8.
- Sub-module lcd_req_fifo, instantiated twice: synchronous FIFO with push, pop, head, full, empty and count outputs, and push-when-full-with-pop support.
- The arbiter FSM and gap counter live in the top module.

Test Plan:
All scenarios use GAP_CYCLES=4 and FIFO_DEPTH=4.
- Single key: kb_valid pulse with kb_data=0x1C at cycle 10 -> lcd_write_en high only at cycle 12, lcd_data=0x1C, grant_src=0, busy high cycles 12-16.
- Tie after reset: kb 0x41 and cpu 0x42 pushed in the same cycle -> writes 0x41 then 0x42, pulses 6 cycles apart.
- Fairness: 3 kb bytes (A1,A2,A3) and 3 cpu bytes (B1,B2,B3) preloaded -> issue order A1,B1,A2,B2,A3,B3.
- Overflow: 6 back-to-back cpu_valid cycles with data 0..5 while idle -> first byte popped early, so 5 accepted (0-4) and byte 5 dropped, cpu_overflow=1. clear_ovf then drops the flag to 0. A drop coinciding with clear_ovf leaves the flag at 1.
- Async reset: assert resetn=0 mid-GAP with 2 bytes queued -> outputs 0 immediately, and no writes after release until new pushes arrive.
